// File: rtl/tdc_chnl_merge_arb.sv
// Merges NUM_CH aligner hit-word streams into one valid/ready stream through
// per-input FIFOs and a round-robin arbiter; FIFO overflow is reported in-band.
module tdc_chnl_merge_arb #(
    parameter int          NUM_CH   = 4,
    parameter int          FIFO_AW  = 2,
    parameter logic [7:0]  MARK_TAG = 8'hE9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [NUM_CH-1:0]     in_valid,
    input  logic [32*NUM_CH-1:0]  in_data,
    output logic                  out_valid,
    output logic [31:0]           out_data,
    output logic [4:0]            out_id,
    input  logic                  out_ready,
    output logic [NUM_CH-1:0]     fifo_full
);

    localparam int              DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] ZERO_CNT = (FIFO_AW+1)'(0);
    localparam logic [FIFO_AW:0] ONE_CNT  = (FIFO_AW+1)'(1);

    // Overflow marker: tag, source index and number of words lost.
    function automatic logic [31:0] make_marker(input logic [4:0] ch, input logic [15:0] cnt);
        return {MARK_TAG, 3'b000, ch, cnt};
    endfunction

    logic [NUM_CH-1:0] empty_s;
    logic [NUM_CH-1:0] pop_s;
    logic [31:0]       rd_data_s [NUM_CH];
    logic              gnt_found_s;
    logic [4:0]        gnt_idx_s;
    logic [31:0]       gnt_data_s;
    logic              load_s;
    logic [4:0]        rr_ptr_r;
    logic [4:0]        rr_ptr_nxt_s;
    logic              out_valid_r;
    logic [31:0]       out_data_r;
    logic [4:0]        out_id_r;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [31:0]        mem_r [DEPTH];
        logic [FIFO_AW-1:0] wr_ptr_r;
        logic [FIFO_AW-1:0] rd_ptr_r;
        logic [FIFO_AW:0]   cnt_r;
        logic [FIFO_AW:0]   cnt_nxt_s;
        logic [15:0]        drop_cnt_r;
        logic [15:0]        drop_cnt_nxt_s;
        logic               wr_s;
        logic [31:0]        wr_data_s;
        logic               full_s;
        logic               full_r;

        assign full_s        = (cnt_r == FULL_CNT);
        assign empty_s[gi]   = (cnt_r == ZERO_CNT);
        assign rd_data_s[gi] = mem_r[rd_ptr_r];
        assign fifo_full[gi] = full_r;

        // Write decision: a pending marker takes priority over new data.
        always_comb begin
            wr_s           = 1'b0;
            wr_data_s      = 32'h0000_0000;
            drop_cnt_nxt_s = drop_cnt_r;
            if ((drop_cnt_r != 16'h0000) && !full_s) begin
                wr_s      = 1'b1;
                wr_data_s = make_marker(5'(gi), drop_cnt_r);
                if (enable && in_valid[gi]) begin
                    drop_cnt_nxt_s = 16'h0001;
                end else begin
                    drop_cnt_nxt_s = 16'h0000;
                end
            end else if (enable && in_valid[gi]) begin
                if (!full_s) begin
                    wr_s      = 1'b1;
                    wr_data_s = in_data[32*gi +: 32];
                end else if (drop_cnt_r != 16'hFFFF) begin
                    drop_cnt_nxt_s = drop_cnt_r + 16'h0001;
                end else begin
                    drop_cnt_nxt_s = drop_cnt_r;
                end
            end else begin
                drop_cnt_nxt_s = drop_cnt_r;
            end
        end

        // Occupancy update from this cycle's write and pop.
        always_comb begin
            case ({wr_s, pop_s[gi]})
                2'b10:   cnt_nxt_s = cnt_r + ONE_CNT;
                2'b01:   cnt_nxt_s = cnt_r - ONE_CNT;
                default: cnt_nxt_s = cnt_r;
            endcase
        end

        // FIFO control state, drop counter and registered full flag.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_r   <= {FIFO_AW{1'b0}};
                rd_ptr_r   <= {FIFO_AW{1'b0}};
                cnt_r      <= ZERO_CNT;
                drop_cnt_r <= 16'h0000;
                full_r     <= 1'b0;
            end else begin
                if (wr_s) begin
                    wr_ptr_r <= wr_ptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
                end
                if (pop_s[gi]) begin
                    rd_ptr_r <= rd_ptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
                end
                cnt_r      <= cnt_nxt_s;
                drop_cnt_r <= drop_cnt_nxt_s;
                full_r     <= (cnt_nxt_s == FULL_CNT);
            end
        end

        // Storage array; contents are only visible once written.
        always_ff @(posedge clk) begin
            if (wr_s) begin
                mem_r[wr_ptr_r] <= wr_data_s;
            end
        end
    end

    assign load_s = !out_valid_r || out_ready;

    // Round-robin pick: lowest non-empty index at/above rr_ptr, else lowest overall.
    always_comb begin
        logic       hi_found_v;
        logic [4:0] hi_idx_v;
        logic       lo_found_v;
        logic [4:0] lo_idx_v;
        hi_found_v = 1'b0;
        hi_idx_v   = 5'd0;
        lo_found_v = 1'b0;
        lo_idx_v   = 5'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (!empty_s[i]) begin
                lo_found_v = 1'b1;
                lo_idx_v   = 5'(i);
                if (5'(i) >= rr_ptr_r) begin
                    hi_found_v = 1'b1;
                    hi_idx_v   = 5'(i);
                end else begin
                    hi_found_v = hi_found_v;
                end
            end else begin
                lo_found_v = lo_found_v;
            end
        end
        gnt_found_s = lo_found_v;
        gnt_idx_s   = hi_found_v ? hi_idx_v : lo_idx_v;
    end

    // Pop strobes and granted read data.
    always_comb begin
        pop_s      = {NUM_CH{1'b0}};
        gnt_data_s = 32'h0000_0000;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_idx_s == 5'(i)) begin
                pop_s[i]   = load_s && gnt_found_s;
                gnt_data_s = rd_data_s[i];
            end else begin
                pop_s[i]   = 1'b0;
            end
        end
    end

    // Pointer advances past the granted input only when a word is taken.
    always_comb begin
        rr_ptr_nxt_s = rr_ptr_r;
        if (load_s && gnt_found_s) begin
            rr_ptr_nxt_s = (gnt_idx_s == 5'(NUM_CH - 1)) ? 5'd0 : gnt_idx_s + 5'd1;
        end else begin
            rr_ptr_nxt_s = rr_ptr_r;
        end
    end

    // Single-entry output register and arbitration pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r    <= 5'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= 32'h0000_0000;
            out_id_r    <= 5'd0;
        end else begin
            rr_ptr_r <= rr_ptr_nxt_s;
            if (load_s) begin
                out_valid_r <= gnt_found_s;
                if (gnt_found_s) begin
                    out_data_r <= gnt_data_s;
                    out_id_r   <= gnt_idx_s;
                end
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_id    = out_id_r;

endmodule

// File: tb/tb_tdc_chnl_merge_arb.sv
// Directed, table-driven bench for tdc_chnl_merge_arb with hand-computed
// expectations for latency, fairness, backpressure, overflow and reset.
module tb_tdc_chnl_merge_arb;

    localparam int NUM_CH = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enable;
    logic [NUM_CH-1:0]    in_valid;
    logic [32*NUM_CH-1:0] in_data;
    logic                 out_valid;
    logic [31:0]          out_data;
    logic [4:0]           out_id;
    logic                 out_ready;
    logic [NUM_CH-1:0]    fifo_full;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] got_d  [$];
    logic [4:0]  got_id [$];

    typedef struct {
        int          ch;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [4];

    tdc_chnl_merge_arb #(.NUM_CH(NUM_CH), .FIFO_AW(2), .MARK_TAG(8'hE9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .fifo_full (fifo_full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = '0;
        in_data  = '0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send(input int ch, input logic [31:0] d);
        in_valid[ch]        = 1'b1;
        in_data[32*ch +: 32] = d;
        tick();
        in_valid = '0;
        in_data  = '0;
    endtask

    task automatic collect(input int n, input int budget);
        int cyc;
        got_d.delete();
        got_id.delete();
        out_ready = 1'b1;
        cyc = 0;
        while (got_d.size() < n && cyc < budget) begin
            if (out_valid) begin
                got_d.push_back(out_data);
                got_id.push_back(out_id);
            end
            tick();
            cyc++;
        end
        check("collect_count", 32'(got_d.size()), 32'(n));
    endtask

    initial begin
        logic [31:0] exp_d [6];
        int          seen;

        vecs[0] = '{ch: 2, data: 32'h1234_5678};
        vecs[1] = '{ch: 0, data: 32'hDEAD_BEEF};
        vecs[2] = '{ch: 3, data: 32'hFFFF_FFFF};
        vecs[3] = '{ch: 1, data: 32'h0000_0000};

        rst_n     = 1'b0;
        enable    = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  out_data, 32'h0);
        check("rst_id",    32'(out_id), 32'd0);
        check("rst_full",  32'(fifo_full), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single-word latency for each vector.
        for (int v = 0; v < 4; v++) begin
            in_valid[vecs[v].ch]           = 1'b1;
            in_data[32*vecs[v].ch +: 32]   = vecs[v].data;
            tick();
            in_valid = '0;
            in_data  = '0;
            check("lat_c1_valid", 32'(out_valid), 32'd0);
            tick();
            check("lat_c2_valid", 32'(out_valid), 32'd1);
            check("lat_c2_data",  out_data, vecs[v].data);
            check("lat_c2_id",    32'(out_id), 32'(vecs[v].ch));
            tick();
            check("lat_c3_valid", 32'(out_valid), 32'd0);
        end

        // Fairness from a fresh pointer.
        do_reset();
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        tick();
        in_valid = '0;
        in_data  = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("fair_valid", 32'(out_valid), 32'd1);
            check("fair_id",    32'(out_id), 32'(k));
            check("fair_data",  out_data, 32'hA0 + 32'(k));
        end
        in_valid = 4'b1001;
        in_data  = {32'hB3, 32'h0, 32'h0, 32'hB0};
        tick();
        in_valid = '0;
        in_data  = '0;
        tick();
        check("fair2_first",  32'(out_id), 32'd0);
        tick();
        check("fair2_second", 32'(out_id), 32'd3);
        check("fair2_data",   out_data, 32'hB3);
        tick();
        check("fair2_idle",   32'(out_valid), 32'd0);

        // Backpressure holds the word stable, then one handshake.
        out_ready = 1'b0;
        send(1, 32'h55AA_1234);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data",  out_data, 32'h55AA_1234);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_no_dup", 32'(out_valid), 32'd0);

        // Input gating.
        enable = 1'b0;
        send(1, 32'h0BAD_0001);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid) seen++;
            tick();
        end
        check("enable_off", 32'(seen), 32'd0);
        enable = 1'b1;

        // Overflow: output register occupied, 4 stored, 3 dropped.
        out_ready = 1'b0;
        send(1, 32'h1000_0000);
        tick();
        for (int k = 1; k <= 7; k++) begin
            send(1, 32'h1000_0000 + 32'(k));
        end
        check("ovf_full", 32'(fifo_full), 32'h2);
        collect(6, 40);
        exp_d[0] = 32'h1000_0000;
        exp_d[1] = 32'h1000_0001;
        exp_d[2] = 32'h1000_0002;
        exp_d[3] = 32'h1000_0003;
        exp_d[4] = 32'h1000_0004;
        exp_d[5] = 32'hE901_0003;
        for (int k = 0; k < 6; k++) begin
            if (k < got_d.size()) begin
                check("ovf_data", got_d[k], exp_d[k]);
                check("ovf_id",   32'(got_id[k]), 32'd1);
            end
        end
        tick();
        check("ovf_drained", 32'(out_valid), 32'd0);
        check("ovf_full_clr", 32'(fifo_full), 32'd0);

        // Marker collides with a new word: old count written, next reports 1.
        out_ready = 1'b0;
        send(0, 32'hC000_0000);
        tick();
        for (int k = 1; k <= 6; k++) begin
            send(0, 32'hC000_0000 + 32'(k));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send(0, 32'hC000_0007);
        collect(6, 40);
        exp_d[0] = 32'hC000_0001;
        exp_d[1] = 32'hC000_0002;
        exp_d[2] = 32'hC000_0003;
        exp_d[3] = 32'hC000_0004;
        exp_d[4] = 32'hE900_0002;
        exp_d[5] = 32'hE900_0001;
        for (int k = 0; k < 6; k++) begin
            if (k < got_d.size()) begin
                check("coll_data", got_d[k], exp_d[k]);
            end
        end
        tick();
        check("coll_drained", 32'(out_valid), 32'd0);

        // Reset mid-stream discards buffered words and pending markers.
        out_ready = 1'b0;
        send(2, 32'h2000_0000);
        tick();
        send(2, 32'h2000_0001);
        send(2, 32'h2000_0002);
        for (int k = 0; k < 6; k++) begin
            send(3, 32'h3000_0000 + 32'(k));
        end
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_full",  32'(fifo_full), 32'd0);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid) seen++;
        end
        check("post_rst_stale", 32'(seen), 32'd0);
        send(3, 32'h7777_0001);
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_data",  out_data, 32'h7777_0001);
        check("post_rst_id",    32'(out_id), 32'd3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
